imem_responder: RTL

- Instruction-memory responder: the memory end of the instruction-fetch interface.
- Accepts fetch requests carrying a PC, reads a word-addressed instruction store and returns the 32-bit instruction in request order after a fixed read latency.
- Supports backpressure, a flush on PC redirect (branch/JAL/JALR), and a side load port for program image initialisation.

---
 rtl/imem_responder_if.sv | 25 ++
 rtl/imem_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/imem_responder_if.sv
// Instruction-fetch bus between a fetch unit (master) and the instruction memory (slave).
// Carries the request/response handshakes, the redirect flush and the program-load port.
interface imem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_instr_o;
  logic        rsp_err_o;
  logic        ld_we_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_i;

  modport master (
    output req_valid_i, req_addr_i, flush_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_instr_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, flush_i, rsp_ready_i, ld_we_i, ld_addr_i, ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_instr_o, rsp_err_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word store read at request acceptance, fixed-latency
// pipeline into an in-order response FIFO, credit-limited, with flush and a load port.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  imem_responder_if.slave  bus
);

  localparam int          AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW     = $clog2(QDEPTH + 1);
  localparam int          STAGES = LATENCY - 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [31:0]   store [DEPTH_WORDS];
  logic [32:0]   fifo_mem [QDEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] outstanding;
  logic          accept, deliver, fifo_wr;
  logic [32:0]   rd_word, fifo_wdata, head;
  logic          unused_ld_lsb;

  // {err, instr}: faulting fetches return a NOP so a speculative consumer stays harmless
  function automatic logic [32:0] fetch_result(input logic [31:0] addr, input logic [31:0] word);
    if (addr[1:0] != 2'b00) return {1'b1, NOP};
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) return {1'b1, NOP};
    return {1'b0, word};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_ld_lsb   = ^bus.ld_addr_i[1:0];
  assign bus.req_ready_o = !rst_i && !bus.flush_i && (outstanding < CW'(QDEPTH));
  assign bus.rsp_valid_o = !rst_i && !bus.flush_i && (fifo_cnt != '0);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign deliver         = bus.rsp_valid_o && bus.rsp_ready_i;
  assign rd_word         = fetch_result(bus.req_addr_i, store[bus.req_addr_i[AW+1:2]]);

  // Load port; a same-cycle read above still sees the pre-write word
  always_ff @(posedge clk_i) begin
    if (bus.ld_we_i && ({2'b00, bus.ld_addr_i[31:2]} < 32'(DEPTH_WORDS)))
      store[bus.ld_addr_i[AW+1:2]] <= bus.ld_data_i;
  end

  generate
    if (STAGES == 0) begin : g_direct
      assign fifo_wr    = accept;
      assign fifo_wdata = rd_word;
    end else begin : g_pipe
      logic [32:0]       data_p [STAGES];
      logic [STAGES-1:0] vld_p;

      // Stage p0 captures the store read at the acceptance edge; later stages only delay
      always_ff @(posedge clk_i) begin
        data_p[0] <= rd_word;
        for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= accept;
          for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      assign fifo_wr    = vld_p[STAGES-1];
      assign fifo_wdata = data_p[STAGES-1];
    end
  endgenerate

  // Response FIFO; the credit limit keeps it from ever overflowing
  always_ff @(posedge clk_i) begin
    if (fifo_wr) fifo_mem[wptr] <= fifo_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      wptr        <= '0;
      rptr        <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (fifo_wr) wptr <= ptr_inc(wptr);
      if (deliver) rptr <= ptr_inc(rptr);
      fifo_cnt    <= fifo_cnt + CW'(fifo_wr) - CW'(deliver);
      outstanding <= outstanding + CW'(accept) - CW'(deliver);
    end
  end

  assign head            = fifo_mem[rptr];
  assign bus.rsp_instr_o = bus.rsp_valid_o ? head[31:0] : '0;
  assign bus.rsp_err_o   = bus.rsp_valid_o ? head[32] : 1'b0;

endmodule
